// File: rtl/br_sched_pkg.sv
// Shared types and constants for the branch-unit issue scheduler.
// THREAD_WIDTH defaults to 2 (four threads) when the build does not define it.
`ifndef THREAD_WIDTH
`define THREAD_WIDTH 2
`endif

package br_sched_pkg;

    localparam int unsigned THREAD_W = `THREAD_WIDTH;
    localparam int unsigned CNT_W    = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    typedef logic [THREAD_W-1:0] thread_id_t;

    // Head-of-FIFO resolution as seen by the scheduler
    typedef struct packed {
        logic       valid;
        logic       ack;
        thread_id_t thread;
    } br_res_t;

endpackage

// File: rtl/br_sched_if.sv
// Scheduler-facing bundle: thread requests, branch-unit status, grants and counts.
// blocked_cnt_o exists only when BR_SCHED_PERF_EN is defined.
interface br_sched_if
    import br_sched_pkg::*;
#(
    parameter int unsigned NUM_THREADS = (1 << `THREAD_WIDTH)
);

    logic                         stall_i;
    logic [NUM_THREADS-1:0]       req_i;
    logic                         br_full_i;
    logic                         br_busy_i;
    logic                         res_valid_i;
    thread_id_t                   res_thread_i;
    logic                         pc_ack_i;
    logic [NUM_THREADS-1:0]       flush_i;
    logic                         drain_i;
    logic [NUM_THREADS-1:0]       gnt_o;
    logic                         issue_en_o;
    thread_id_t                   gnt_thread_o;
    logic                         drain_done_o;
    logic [NUM_THREADS*CNT_W-1:0] outstanding_o;
`ifdef BR_SCHED_PERF_EN
    logic [31:0]                  blocked_cnt_o;
`endif

    modport master (
        output stall_i, req_i, br_full_i, br_busy_i, res_valid_i, res_thread_i,
               pc_ack_i, flush_i, drain_i,
        input  gnt_o, issue_en_o, gnt_thread_o, drain_done_o, outstanding_o
`ifdef BR_SCHED_PERF_EN
        , input blocked_cnt_o
`endif
    );

    modport slave (
        input  stall_i, req_i, br_full_i, br_busy_i, res_valid_i, res_thread_i,
               pc_ack_i, flush_i, drain_i,
        output gnt_o, issue_en_o, gnt_thread_o, drain_done_o, outstanding_o
`ifdef BR_SCHED_PERF_EN
        , output blocked_cnt_o
`endif
    );

endinterface

// File: rtl/br_sched_rr_pick.sv
// Combinational round-robin selector: lowest set request at or above ptr,
// wrapping to the lowest set request overall.
module br_sched_rr_pick
    import br_sched_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    input  thread_id_t   ptr,
    output logic [N-1:0] onehot,
    output thread_id_t   idx,
    output logic         valid
);

    logic [N-1:0] masked;
    logic [N-1:0] src;

    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (i >= int'(ptr)) masked[i] = req[i];
        end
        src = (|masked) ? masked : req;
    end

    // Descending scan so the lowest set bit of src wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = |req;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (src[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = THREAD_W'(i);
            end
        end
    end

endmodule

// File: rtl/br_sched.sv
// Branch-unit issue scheduler: per-thread outstanding limit, round-robin grant, drain.
// Define BR_SCHED_PERF_EN to add the saturating blocked-cycle counter blocked_cnt_o.
module br_sched
    import br_sched_pkg::*;
#(
    parameter int unsigned NUM_THREADS = (1 << `THREAD_WIDTH),
    parameter int unsigned MAX_OUT     = 2
) (
    input  logic     clk,
    input  logic     rst,
    br_sched_if.slave bus
);

    sched_state_e           state;
    sched_state_e           state_nxt;
    thread_id_t             rr_ptr;
    thread_id_t             rr_ptr_nxt;
    logic [CNT_W-1:0]       count     [NUM_THREADS];
    logic [CNT_W-1:0]       count_nxt [NUM_THREADS];
    logic [NUM_THREADS-1:0] elig;
    logic [NUM_THREADS-1:0] pick_oh;
    logic [NUM_THREADS-1:0] dec;
    thread_id_t             pick_idx;
    logic                   pick_vld;
    logic                   state_run;
    logic                   run_ok;
    logic                   all_zero;
    logic                   retire;
    br_res_t                res;

    assign res    = '{valid: bus.res_valid_i, ack: bus.pc_ack_i, thread: bus.res_thread_i};
    assign retire = res.valid & res.ack;

    // Gated by rst so the grant outputs read zero while reset is held
    assign run_ok = rst & state_run & ~bus.stall_i & ~bus.br_full_i & ~bus.drain_i;

    always_comb begin
        elig     = '0;
        dec      = '0;
        all_zero = 1'b1;
        for (int t = 0; t < int'(NUM_THREADS); t++) begin
            elig[t] = run_ok & bus.req_i[t] & ~bus.flush_i[t]
                      & (count[t] < CNT_W'(MAX_OUT));
            dec[t]  = retire & (res.thread == THREAD_W'(t)) & (count[t] != '0);
            if (count[t] != '0) all_zero = 1'b0;
        end
    end

    br_sched_rr_pick #(.N(NUM_THREADS)) rr_pick (
        .req    (elig),
        .ptr    (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    assign bus.gnt_o        = pick_oh;
    assign bus.issue_en_o   = pick_vld;
    assign bus.gnt_thread_o = pick_vld ? pick_idx : '0;

    // Flush wins; a grant and retire to the same thread cancel out
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (pick_vld) begin
            rr_ptr_nxt = (pick_idx == THREAD_W'(NUM_THREADS - 1)) ? '0
                                                                 : pick_idx + THREAD_W'(1);
        end
        for (int t = 0; t < int'(NUM_THREADS); t++) begin
            count_nxt[t] = count[t];
            if (bus.flush_i[t])              count_nxt[t] = '0;
            else if (pick_oh[t] && !dec[t])  count_nxt[t] = count[t] + CNT_W'(1);
            else if (dec[t] && !pick_oh[t])  count_nxt[t] = count[t] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_RUN;
        end else if (!bus.stall_i) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (bus.drain_i) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!bus.br_busy_i && all_zero) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        state_run        = 1'b0;
        bus.drain_done_o = 1'b0;
        case (state)
            ST_RUN:  state_run        = 1'b1;
            ST_DONE: bus.drain_done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            for (int t = 0; t < int'(NUM_THREADS); t++) count[t] <= '0;
        end else if (!bus.stall_i) begin
            rr_ptr <= rr_ptr_nxt;
            for (int t = 0; t < int'(NUM_THREADS); t++) count[t] <= count_nxt[t];
        end
    end

    always_comb begin
        bus.outstanding_o = '0;
        for (int t = 0; t < int'(NUM_THREADS); t++) begin
            bus.outstanding_o[t*CNT_W +: CNT_W] = count[t];
        end
    end

`ifdef BR_SCHED_PERF_EN
    logic [31:0] blocked_cnt;

    // Cycles where some thread wanted the unit but nobody got it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blocked_cnt <= '0;
        end else if (!bus.stall_i && (|bus.req_i) && !pick_vld && (blocked_cnt != '1)) begin
            blocked_cnt <= blocked_cnt + 32'd1;
        end
    end

    assign bus.blocked_cnt_o = blocked_cnt;
`endif

endmodule

// File: tb/tb_br_sched.sv
// Directed self-checking bench for br_sched (four threads, two outstanding per thread).
module tb_br_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    br_sched_if #(.NUM_THREADS(4)) bus ();

    br_sched #(.NUM_THREADS(4), .MAX_OUT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_i      = 1'b0;
        bus.req_i        = 4'b0000;
        bus.br_full_i    = 1'b0;
        bus.br_busy_i    = 1'b0;
        bus.res_valid_i  = 1'b0;
        bus.res_thread_i = 2'd0;
        bus.pc_ack_i     = 1'b0;
        bus.flush_i      = 4'b0000;
        bus.drain_i      = 1'b0;
    endtask

    task automatic retire(input logic [1:0] t);
        bus.res_valid_i  = 1'b1;
        bus.pc_ack_i     = 1'b1;
        bus.res_thread_i = t;
    endtask

    task automatic test_reset();
        bus.req_i = 4'b1111;
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt_o); end
        checks++; if (bus.issue_en_o !== 1'b0) begin errors++; $display("FAIL reset_issue: got %b want 0", bus.issue_en_o); end
        checks++; if (bus.gnt_thread_o !== 2'd0) begin errors++; $display("FAIL reset_thread: got %0d want 0", bus.gnt_thread_o); end
        checks++; if (bus.drain_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.drain_done_o); end
        step();
        checks++; if (bus.outstanding_o !== 12'h000) begin errors++; $display("FAIL reset_outstanding: got %h want 000", bus.outstanding_o); end
        rst = 1'b1;
        idle();
        step();
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        for (int k = 0; k < 4; k++) begin
            bus.req_i = 4'b1111;
            exp = 4'b0001 << k;
            #1;
            checks++; if (bus.gnt_o !== exp) begin errors++; $display("FAIL fair_gnt%0d: got %b want %b", k, bus.gnt_o, exp); end
            checks++; if (bus.gnt_thread_o !== 2'(k)) begin errors++; $display("FAIL fair_thread%0d: got %0d want %0d", k, bus.gnt_thread_o, k); end
            step();
        end
        bus.req_i = 4'b0000;
        #1;
        checks++; if (bus.outstanding_o !== 12'h249) begin errors++; $display("FAIL fair_counts: got %h want 249", bus.outstanding_o); end
        for (int k = 0; k < 4; k++) begin
            retire(2'(k));
            step();
        end
        idle();
        #1;
        checks++; if (bus.outstanding_o !== 12'h000) begin errors++; $display("FAIL fair_clean: got %h want 000", bus.outstanding_o); end
    endtask

    task automatic test_limit();
        bus.req_i = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL limit_gnt%0d: got %b want 0010", k, bus.gnt_o); end
            step();
        end
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL limit_block: got %b want 0000", bus.gnt_o); end
        checks++; if (bus.outstanding_o[5:3] !== 3'd2) begin errors++; $display("FAIL limit_count: got %0d want 2", bus.outstanding_o[5:3]); end
        step();
        retire(2'd1);
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL limit_retire_cycle: got %b want 0000", bus.gnt_o); end
        step();
        bus.res_valid_i = 1'b0;
        bus.pc_ack_i    = 1'b0;
        #1;
        checks++; if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL limit_third: got %b want 0010", bus.gnt_o); end
        step();
        bus.req_i = 4'b0000;
        retire(2'd1);
        step();
        step();
        idle();
        #1;
        checks++; if (bus.outstanding_o !== 12'h000) begin errors++; $display("FAIL limit_clean: got %h want 000", bus.outstanding_o); end
    endtask

    task automatic test_simultaneous();
        bus.req_i = 4'b0100;
        #1;
        checks++; if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL simul_first: got %b want 0100", bus.gnt_o); end
        step();
        retire(2'd2);
        #1;
        checks++; if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL simul_gnt: got %b want 0100", bus.gnt_o); end
        step();
        checks++; if (bus.outstanding_o !== 12'h040) begin errors++; $display("FAIL simul_hold: got %h want 040", bus.outstanding_o); end
        bus.flush_i = 4'b0100;
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL simul_flush_gnt: got %b want 0000", bus.gnt_o); end
        step();
        idle();
        #1;
        checks++; if (bus.outstanding_o !== 12'h000) begin errors++; $display("FAIL simul_flush: got %h want 000", bus.outstanding_o); end
    endtask

    task automatic test_backpressure();
        bus.req_i = 4'b0101;
        #1;
        checks++; if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL bp_wrap: got %b want 0001", bus.gnt_o); end
        step();
        bus.br_full_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL bp_full%0d: got %b want 0000", k, bus.gnt_o); end
            step();
        end
        checks++; if (bus.outstanding_o !== 12'h001) begin errors++; $display("FAIL bp_full_counts: got %h want 001", bus.outstanding_o); end
        bus.br_full_i = 1'b0;
        bus.stall_i   = 1'b1;
        retire(2'd0);
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL bp_stall: got %b want 0000", bus.gnt_o); end
        step();
        step();
        checks++; if (bus.outstanding_o !== 12'h001) begin errors++; $display("FAIL bp_stall_counts: got %h want 001", bus.outstanding_o); end
        idle();
        bus.req_i = 4'b0101;
        #1;
        checks++; if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL bp_ptr_gnt: got %b want 0100", bus.gnt_o); end
        checks++; if (bus.gnt_thread_o !== 2'd2) begin errors++; $display("FAIL bp_ptr_thread: got %0d want 2", bus.gnt_thread_o); end
        step();
        bus.req_i = 4'b0000;
        retire(2'd2);
        step();
        idle();
        #1;
        checks++; if (bus.outstanding_o !== 12'h001) begin errors++; $display("FAIL bp_clean: got %h want 001", bus.outstanding_o); end
    endtask

    task automatic test_drain();
        bus.drain_i   = 1'b1;
        bus.br_busy_i = 1'b1;
        bus.req_i     = 4'b1111;
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL drain_req: got %b want 0000", bus.gnt_o); end
        step();
        bus.drain_i = 1'b0;
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL drain_state_gnt: got %b want 0000", bus.gnt_o); end
        checks++; if (bus.drain_done_o !== 1'b0) begin errors++; $display("FAIL drain_busy_done: got %b want 0", bus.drain_done_o); end
        step();
        retire(2'd0);
        step();
        bus.res_valid_i = 1'b0;
        bus.pc_ack_i    = 1'b0;
        bus.br_busy_i   = 1'b0;
        #1;
        checks++; if (bus.drain_done_o !== 1'b0) begin errors++; $display("FAIL drain_early_done: got %b want 0", bus.drain_done_o); end
        checks++; if (bus.outstanding_o !== 12'h000) begin errors++; $display("FAIL drain_counts: got %h want 000", bus.outstanding_o); end
        step();
        checks++; if (bus.drain_done_o !== 1'b1) begin errors++; $display("FAIL drain_pulse: got %b want 1", bus.drain_done_o); end
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL drain_done_gnt: got %b want 0000", bus.gnt_o); end
        step();
        checks++; if (bus.drain_done_o !== 1'b0) begin errors++; $display("FAIL drain_pulse_end: got %b want 0", bus.drain_done_o); end
        checks++; if (bus.gnt_o !== 4'b1000) begin errors++; $display("FAIL drain_resume: got %b want 1000", bus.gnt_o); end
        step();
        bus.req_i = 4'b0000;
        retire(2'd3);
        step();
        idle();
    endtask

    task automatic test_reset_active();
        bus.req_i = 4'b1111;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.gnt_o !== 4'b0000) begin errors++; $display("FAIL rstact_gnt: got %b want 0000", bus.gnt_o); end
        checks++; if (bus.outstanding_o !== 12'h000) begin errors++; $display("FAIL rstact_counts: got %h want 000", bus.outstanding_o); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL rstact_resume: got %b want 0001", bus.gnt_o); end
        step();
        bus.req_i = 4'b0000;
        retire(2'd0);
        step();
        idle();
    endtask

    task automatic test_reset_mid_drain();
        bus.drain_i   = 1'b1;
        bus.br_busy_i = 1'b1;
        step();
        bus.drain_i = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (bus.drain_done_o !== 1'b0) begin errors++; $display("FAIL abort_done_rst: got %b want 0", bus.drain_done_o); end
        step();
        rst = 1'b1;
        bus.br_busy_i = 1'b0;
        bus.req_i     = 4'b0001;
        #1;
        checks++; if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL abort_run: got %b want 0001", bus.gnt_o); end
        step();
        idle();
        #1;
        checks++; if (bus.drain_done_o !== 1'b0) begin errors++; $display("FAIL abort_no_pulse: got %b want 0", bus.drain_done_o); end
        retire(2'd0);
        step();
        idle();
    endtask

`ifdef BR_SCHED_PERF_EN
    task automatic test_perf();
        rst = 1'b0;
        #1;
        checks++; if (bus.blocked_cnt_o !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d want 0", bus.blocked_cnt_o); end
        step();
        rst = 1'b1;
        bus.req_i     = 4'b0001;
        bus.br_full_i = 1'b1;
        step(); step(); step();
        bus.br_full_i = 1'b0;
        bus.stall_i   = 1'b1;
        step(); step();
        bus.stall_i = 1'b0;
        bus.req_i   = 4'b0000;
        step();
        checks++; if (bus.blocked_cnt_o !== 32'd3) begin errors++; $display("FAIL perf_count: got %0d want 3", bus.blocked_cnt_o); end
        bus.req_i = 4'b0001;
        step();
        checks++; if (bus.blocked_cnt_o !== 32'd3) begin errors++; $display("FAIL perf_grant_hold: got %0d want 3", bus.blocked_cnt_o); end
        idle();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        test_reset();
        test_fairness();
        test_limit();
        test_simultaneous();
        test_backpressure();
        test_drain();
        test_reset_active();
        test_reset_mid_drain();
`ifdef BR_SCHED_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_sched.md
BR_SCHED -- requirements
Module: br_sched

Interface
REQ-001 SHALL have parameter NUM_THREADS, default (1 << `THREAD_WIDTH), number of hardware threads requesting the branch unit.
REQ-002 SHALL have parameter MAX_OUT, default 2, maximum unresolved branches per thread (1..7).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_i  input  1  pipeline stall; no grant and no state or counter change while high.
REQ-006 SHALL have port req_i  input  NUM_THREADS  per-thread branch issue request.
REQ-007 SHALL have port br_full_i  input  1  branch unit FIFO full.
REQ-008 SHALL have port br_busy_i  input  1  branch unit holds work (FIFO non-empty or station busy).
REQ-009 SHALL have port res_valid_i  input  1  head-of-FIFO resolution valid.
REQ-010 SHALL have port res_thread_i  input  `THREAD_WIDTH  thread of the head resolution.
REQ-011 SHALL have port pc_ack_i  input  1  fetch consumed the head resolution.
REQ-012 SHALL have port flush_i  input  NUM_THREADS  per-thread kill; clears that thread's outstanding count.
REQ-013 SHALL have port drain_i  input  1  request to stop granting and empty the branch unit.
REQ-014 SHALL have port gnt_o  output  NUM_THREADS  one-hot grant, combinational, same cycle.
REQ-015 SHALL have port issue_en_o  output  1  OR of gnt_o, drives the branch unit issue enable.
REQ-016 SHALL have port gnt_thread_o  output  `THREAD_WIDTH  encoded index of granted thread; 0 when no grant.
REQ-017 SHALL have port drain_done_o  output  1  one-cycle pulse on drain completion.
REQ-018 SHALL have port outstanding_o  output  NUM_THREADS*3  packed per-thread outstanding counts.

Function
REQ-019 SHALL implement FSM RUN, DRAIN, DONE, registered.
REQ-020 SHALL transition RUN->DRAIN when drain_i=1; DRAIN->DONE when br_busy_i=0 and all counts are 0; DONE->RUN unconditionally next cycle.
REQ-021 SHALL assert drain_done_o only in state DONE.
REQ-022 SHALL mark thread t eligible when req_i[t]=1, count[t]<MAX_OUT, flush_i[t]=0, br_full_i=0, stall_i=0, state=RUN and drain_i=0.
REQ-023 SHALL grant at most one eligible thread per cycle by round-robin, searching from registered pointer rr_ptr upward with wrap at NUM_THREADS.
REQ-024 SHALL load rr_ptr with (granted index + 1) mod NUM_THREADS on a grant, else hold it.
REQ-025 SHALL increment count[t] on grant to t and decrement it when res_valid_i=1, pc_ack_i=1 and res_thread_i=t; simultaneous grant and retire to the same t SHALL leave it unchanged.
REQ-026 SHALL give flush_i[t] priority: count[t] becomes 0 regardless of same-cycle grant or retire.
REQ-027 SHALL never underflow a count (retire at 0 ignored) and never exceed MAX_OUT.
REQ-028 SHALL drive all registered state only from clk edges; stall_i freezes FSM, rr_ptr and counts.

Reset
REQ-029 SHALL on rst=0 asynchronously set state=RUN, rr_ptr=0, all counts 0; outputs then gnt_o=0, issue_en_o=0, gnt_thread_o=0, drain_done_o=0, outstanding_o=0.
REQ-030 SHALL treat reset mid-drain as abort: post-reset state RUN, no drain_done_o pulse.

Configuration
REQ-031 SHALL, with BR_SCHED_PERF_EN defined, add output blocked_cnt_o (32 bits): increments each non-stalled cycle in which req_i is non-zero and no grant issues, saturating at all-ones, cleared by reset.
REQ-032 SHALL, without BR_SCHED_PERF_EN, omit blocked_cnt_o and all its logic.

Structure
REQ-033 SHALL place the FSM state enum and MAX_OUT count width in the shared struct/constants headers alongside the branch types.
REQ-034 SHALL contain one sub-module, rr_pick, a combinational round-robin priority selector (request vector, pointer -> one-hot, index, valid).

Verification
REQ-035 Reset: rst=0 during active grants -> next cycle gnt_o=0, outstanding_o=0, state RUN.
REQ-036 Fairness: NUM_THREADS=4, req_i=4'b1111 for 4 cycles, no retires, MAX_OUT=2 -> grants 0,1,2,3 in order.
REQ-037 Limit: thread 1 alone requesting, no retires -> exactly 2 grants, then gnt_o=0; one retire of thread 1 -> third grant next cycle.
REQ-038 Simultaneous: grant to thread 2 and retire of thread 2 in same cycle with count=1 -> count stays 1; flush_i[2] same cycle -> count 0.
REQ-039 Backpressure: br_full_i=1 or stall_i=1 with req_i=4'b0101 -> gnt_o=0, rr_ptr and counts unchanged.
REQ-040 Drain: drain_i=1 with counts {1,0,0,0}, br_busy_i=1 -> no grants; after retire and br_busy_i=0, drain_done_o pulses once, then granting resumes.
